// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter sharing one register-file write port.
// Per-requester FIFOs drain round-robin into a registered we/rd/wd stage; pending_mask exposes in-flight rds.
module regfile_wb_arbiter #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DEPTH  = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     a_valid,
   output logic                     a_ready,
   input  logic [ADDR_W-1:0]        a_rd,
   input  logic [DATA_W-1:0]        a_wd,
   input  logic                     b_valid,
   output logic                     b_ready,
   input  logic [ADDR_W-1:0]        b_rd,
   input  logic [DATA_W-1:0]        b_wd,
   output logic                     rf_we,
   output logic [ADDR_W-1:0]        rf_rd,
   output logic [DATA_W-1:0]        rf_wd,
   output logic [(2**ADDR_W)-1:0]   pending_mask
);

   localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW   = PW + 1;
   localparam int unsigned NREG = 2 ** ADDR_W;

   // Index 0 = requester A, index 1 = requester B
   logic [ADDR_W-1:0] r_rd  [2][DEPTH];
   logic [DATA_W-1:0] r_wd  [2][DEPTH];
   logic [PW-1:0]     r_wp  [2];
   logic [PW-1:0]     r_rp  [2];
   logic [CW-1:0]     r_cnt [2];
   logic              r_last_b;
   logic              r_rf_we;
   logic [ADDR_W-1:0] r_rf_rd;
   logic [DATA_W-1:0] r_rf_wd;

   logic [1:0]        w_in_valid;
   logic [ADDR_W-1:0] w_in_rd [2];
   logic [DATA_W-1:0] w_in_wd [2];
   logic [1:0]        w_ready;
   logic [1:0]        w_push;
   logic [1:0]        w_nonempty;
   logic [1:0]        w_pop;
   logic [ADDR_W-1:0] w_head_rd;
   logic [DATA_W-1:0] w_head_wd;
   logic [NREG-1:0]   w_mask;

   // Handshake, x0 filter and round-robin pick (tie goes to the side not granted last)
   always_comb begin
      w_in_valid = {b_valid, a_valid};
      w_in_rd[0] = a_rd;
      w_in_rd[1] = b_rd;
      w_in_wd[0] = a_wd;
      w_in_wd[1] = b_wd;
      w_ready    = '0;
      w_push     = '0;
      w_nonempty = '0;
      for (int s = 0; s < 2; s++) begin
         w_ready[s]    = !rst && (r_cnt[s] != CW'(DEPTH));
         w_push[s]     = w_in_valid[s] && w_ready[s] && (w_in_rd[s] != '0);
         w_nonempty[s] = (r_cnt[s] != '0);
      end
      w_pop[0]  = w_nonempty[0] && (!w_nonempty[1] || r_last_b);
      w_pop[1]  = w_nonempty[1] && !w_pop[0];
      w_head_rd = w_pop[0] ? r_rd[0][r_rp[0]] : r_rd[1][r_rp[1]];
      w_head_wd = w_pop[0] ? r_wd[0][r_rp[0]] : r_wd[1][r_rp[1]];
   end

   // Occupied FIFO slots plus the write stage mark their rd as pending
   always_comb begin
      w_mask = '0;
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < r_cnt[s]) begin
               w_mask[r_rd[s][r_rp[s] + PW'(i)]] = 1'b1;
            end
         end
      end
      if (r_rf_we) begin
         w_mask[r_rf_rd] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < 2; s++) begin
            r_wp[s]  <= '0;
            r_rp[s]  <= '0;
            r_cnt[s] <= '0;
         end
         r_last_b <= 1'b1;
         r_rf_we  <= 1'b0;
         r_rf_rd  <= '0;
         r_rf_wd  <= '0;
      end else begin
         for (int s = 0; s < 2; s++) begin
            if (w_push[s]) begin
               r_rd[s][r_wp[s]] <= w_in_rd[s];
               r_wd[s][r_wp[s]] <= w_in_wd[s];
               r_wp[s]          <= r_wp[s] + PW'(1);
            end
            if (w_pop[s]) begin
               r_rp[s] <= r_rp[s] + PW'(1);
            end
            if (w_push[s] && !w_pop[s]) begin
               r_cnt[s] <= r_cnt[s] + CW'(1);
            end else if (w_pop[s] && !w_push[s]) begin
               r_cnt[s] <= r_cnt[s] - CW'(1);
            end
         end
         r_rf_we <= |w_pop;
         if (|w_pop) begin
            r_rf_rd  <= w_head_rd;
            r_rf_wd  <= w_head_wd;
            r_last_b <= w_pop[1];
         end
      end
   end

   assign a_ready      = w_ready[0];
   assign b_ready      = w_ready[1];
   assign rf_we        = r_rf_we;
   assign rf_rd        = r_rf_rd;
   assign rf_wd        = r_rf_wd;
   assign pending_mask = w_mask;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: a driver feeds per-requester source queues and records accepted
// writes; a negedge monitor checks every write-port cycle, pending_mask and ready against them.
module tb_regfile_wb_arbiter;

   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 5;
   localparam int unsigned DEPTH = 2;
   localparam int unsigned NREG  = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          a_valid, b_valid;
   logic          a_ready, b_ready;
   logic [AW-1:0] a_rd, b_rd;
   logic [DW-1:0] a_wd, b_wd;
   logic          rf_we;
   logic [AW-1:0] rf_rd;
   logic [DW-1:0] rf_wd;
   logic [NREG-1:0] pending_mask;

   always #5 clk = ~clk;

   regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_wd(a_wd),
      .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_wd(b_wd),
      .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd), .pending_mask(pending_mask)
   );

   typedef struct { logic [AW-1:0] rd; logic [DW-1:0] wd; } item_t;
   typedef struct { logic [AW-1:0] rd; logic [DW-1:0] wd; int stamp; } ent_t;

   item_t sa[$], sb[$];      // writes still to be offered
   ent_t  qa[$], qb[$];      // accepted, not yet seen on the write port
   int    order_q[$];        // optional required rf_rd sequence
   int    total = 0;
   int    bad   = 0;
   int    cyc   = 0;
   bit    mon_en = 1'b0;
   bit    last_b = 1'b1;

   logic [NREG-1:0] em;
   bit              ea, eb;
   int              side;
   ent_t            e;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: entries accepted before the current edge are eligible for the pop made at it
   always @(negedge clk) begin
      if (mon_en) begin
         em = '0;
         foreach (qa[i]) em[qa[i].rd] = 1'b1;
         foreach (qb[i]) em[qb[i].rd] = 1'b1;
         check("pending_mask", 64'(pending_mask), 64'(em));
         ea = (qa.size() > 0) && (qa[0].stamp < cyc);
         eb = (qb.size() > 0) && (qb[0].stamp < cyc);
         check("rf_we", 64'(rf_we), 64'(ea || eb));
         if (rf_we && (ea || eb)) begin
            if (ea && eb) side = last_b ? 0 : 1;
            else side = ea ? 0 : 1;
            e = (side == 0) ? qa[0] : qb[0];
            check("rf_rd", 64'(rf_rd), 64'(e.rd));
            check("rf_wd", 64'(rf_wd), 64'(e.wd));
            if (side == 0) void'(qa.pop_front());
            else void'(qb.pop_front());
            last_b = (side == 1);
            if (order_q.size() > 0) begin
               check("order_rd", 64'(rf_rd), 64'(order_q[0]));
               void'(order_q.pop_front());
            end
         end
         check("a_ready", 64'(a_ready), 64'(!rst && (qa.size() != DEPTH)));
         check("b_ready", 64'(b_ready), 64'(!rst && (qb.size() != DEPTH)));
      end
   end

   // Entered and left at posedge+2
   task automatic run(input int n, input bit gate);
      for (int k = 0; k < n; k++) begin
         bit    hsa, hsb;
         item_t it;
         a_valid = (sa.size() > 0) && (!gate || ($urandom_range(0, 3) != 0));
         b_valid = (sb.size() > 0) && (!gate || ($urandom_range(0, 3) != 0));
         if (sa.size() > 0) begin a_rd = sa[0].rd; a_wd = sa[0].wd; end
         if (sb.size() > 0) begin b_rd = sb[0].rd; b_wd = sb[0].wd; end
         #1;
         hsa = a_valid && a_ready;
         hsb = b_valid && b_ready;
         @(posedge clk);
         #1;
         if (hsa) begin
            it = sa.pop_front();
            if (it.rd != '0) qa.push_back('{rd: it.rd, wd: it.wd, stamp: cyc});
         end
         if (hsb) begin
            it = sb.pop_front();
            if (it.rd != '0) qb.push_back('{rd: it.rd, wd: it.wd, stamp: cyc});
         end
         a_valid = 1'b0;
         b_valid = 1'b0;
         #1;
      end
   endtask

   // Reset discards everything queued in the DUT, so the bench forgets it too
   task automatic do_reset();
      rst     = 1'b1;
      a_valid = 1'b0;
      b_valid = 1'b0;
      @(posedge clk);
      #1;
      qa.delete(); qb.delete(); sa.delete(); sb.delete(); order_q.delete();
      last_b = 1'b1;
      mon_en = 1'b1;
      check("rst_rf_we", 64'(rf_we), 64'(0));
      check("rst_pending", 64'(pending_mask), 64'(0));
      check("rst_rf_rd", 64'(rf_rd), 64'(0));
      check("rst_rf_wd", 64'(rf_wd), 64'(0));
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
      a_rd = '0; a_wd = '0; b_rd = '0; b_wd = '0;
      do_reset();

      // Single write, latency and pending_mask lifetime
      sa.push_back('{rd: 5'd5, wd: 32'hDEADBEEF});
      run(1, 1'b0);
      check("t1_accepted", 64'(sa.size()), 64'(0));
      run(4, 1'b0);
      check("t1_drained", 64'(qa.size()), 64'(0));

      // Both held valid: strict alternation starting with A
      do_reset();
      for (int i = 1; i <= 4; i++) begin
         sa.push_back('{rd: AW'(i), wd: 32'hA000_0000 + 32'(i)});
         sb.push_back('{rd: AW'(10 + i), wd: 32'hB000_0000 + 32'(i)});
      end
      order_q = '{1, 11, 2, 12, 3, 13, 4, 14};
      run(12, 1'b0);
      check("t2_order_done", 64'(order_q.size()), 64'(0));

      // A burst alone, then A burst against continuous B
      for (int i = 0; i < 4; i++) sa.push_back('{rd: AW'(21 + i), wd: 32'hC0DE_0000 + 32'(i)});
      run(8, 1'b0);
      check("t3_alone_done", 64'(qa.size() + sa.size()), 64'(0));
      for (int i = 0; i < 6; i++) begin
         sa.push_back('{rd: AW'(1 + i), wd: 32'h5A00_0000 + 32'(i)});
         sb.push_back('{rd: AW'(16 + i), wd: 32'h6B00_0000 + 32'(i)});
      end
      run(20, 1'b0);
      check("t3_bp_done", 64'(qa.size() + qb.size() + sa.size() + sb.size()), 64'(0));

      // x0 write is consumed without reaching the port
      sa.push_back('{rd: 5'd0, wd: 32'h0000_1234});
      run(1, 1'b0);
      check("t4_x0_accepted", 64'(sa.size()), 64'(0));
      run(3, 1'b0);

      // Reset with both FIFOs loaded: nothing may come out afterwards
      for (int i = 0; i < 6; i++) begin
         sa.push_back('{rd: AW'(7 + i), wd: 32'h7700_0000 + 32'(i)});
         sb.push_back('{rd: AW'(25 + i), wd: 32'h8800_0000 + 32'(i)});
      end
      run(4, 1'b0);
      do_reset();
      run(6, 1'b0);

      // Random traffic including x0
      for (int i = 0; i < 1000; i++) begin
         sa.push_back('{rd: AW'($urandom_range(0, 31)), wd: $urandom});
         sb.push_back('{rd: AW'($urandom_range(0, 31)), wd: $urandom});
      end
      run(3000, 1'b1);
      check("t6_src_drained", 64'(sa.size() + sb.size()), 64'(0));
      run(10, 1'b0);
      check("t6_all_emitted", 64'(qa.size() + qb.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
